// File: rtl/fir_pkg.sv
// Shared defaults and width constants for the FIR decimating output buffer.
package fir_pkg;

    localparam int IN_W_DEF  = 19;
    localparam int OUT_W_DEF = 16;
    localparam int DECIM_DEF = 2;
    localparam int DEPTH_DEF = 8;

    // Rounding drops RND_SHIFT_DEF LSBs; the sum is formed one bit wider than the input.
    localparam int RND_SHIFT_DEF = IN_W_DEF - OUT_W_DEF;
    localparam int SUM_W_DEF     = IN_W_DEF + 1;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; a write while full is accepted only alongside a pop.
module fir_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_wr, do_rd;

    assign empty_o   = (level_q == '0);
    assign full_o    = (level_q == (AW+1)'(DEPTH));
    assign level_o   = level_q;
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    assign do_rd = rd_en_i & ~empty_o;
    assign do_wr = wr_en_i & (~full_o | do_rd);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_wr, do_rd})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/fir_decim_buf.sv
// Decimates the FIR output stream, rounds/saturates kept samples to OUT_W bits and buffers them for a ready/valid consumer.
module fir_decim_buf
    import fir_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int DECIM = DECIM_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [IN_W-1:0]        in_data,
    input  logic                   in_valid,
    output logic [OUT_W-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
);

    localparam int SHIFT = IN_W - OUT_W;
    localparam int SUM_W = IN_W + 1;
    localparam int PH_W  = cnt_width(DECIM);

    localparam logic [SUM_W-1:0] RND_ADD = SUM_W'(1 << SHIFT) >> 1;
    localparam logic [SUM_W-1:0] SAT_MAX = {{(SUM_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(DECIM - 1);

    function automatic logic [OUT_W-1:0] round_sat(input logic [IN_W-1:0] x);
        logic [SUM_W-1:0] sum;
        sum = ({1'b0, x} + RND_ADD) >> SHIFT;
        if (sum > SAT_MAX) return '1;
        return sum[OUT_W-1:0];
    endfunction

    logic [PH_W-1:0]  phase_q, phase_d;
    logic             overflow_q, overflow_d;
    logic             keep, full, empty;
    logic [OUT_W-1:0] conv_data;

    assign keep      = in_valid && (phase_q == '0);
    assign conv_data = round_sat(in_data);

    // Gap cycles hold the phase so decimation counts samples, not clocks.
    always_comb begin
        phase_d = phase_q;
        if (in_valid) phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
    end

    // When full, out_valid is high, so out_ready alone decides whether a pop frees a slot.
    assign overflow_d = overflow_q | (keep & full & ~out_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            overflow_q <= overflow_d;
        end
    end

    fir_sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (keep),
        .wr_data_i (conv_data),
        .rd_en_i   (out_ready),
        .rd_data_o (out_data),
        .empty_o   (empty),
        .full_o    (full),
        .level_o   (level)
    );

    assign out_valid = ~empty;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_fir_decim_buf.sv
// Random and directed stimulus for two fir_decim_buf instances (DECIM=1 and DECIM=2) against a queue-based reference.
module tb_fir_decim_buf;

    localparam int IN_W  = 19;
    localparam int OUT_W = 16;
    localparam int DEPTH = 8;
    localparam int SHIFT = IN_W - OUT_W;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [IN_W-1:0]  in_data1 = '0, in_data2 = '0;
    logic             in_valid1 = 1'b0, in_valid2 = 1'b0;
    logic             out_ready1 = 1'b0, out_ready2 = 1'b0;
    logic [OUT_W-1:0] out_data1, out_data2;
    logic             out_valid1, out_valid2;
    logic [3:0]       level1, level2;
    logic             overflow1, overflow2;

    int n_tests = 0;
    int n_fail  = 0;

    int q1[$];
    int q2[$];
    int ph1 = 0, ph2 = 0;
    bit ov1 = 1'b0, ov2 = 1'b0;

    always #5 clk = ~clk;

    fir_decim_buf #(.IN_W(IN_W), .OUT_W(OUT_W), .DECIM(1), .DEPTH(DEPTH)) u_d1 (
        .clk(clk), .rst(rst), .in_data(in_data1), .in_valid(in_valid1),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
        .level(level1), .overflow(overflow1)
    );

    fir_decim_buf #(.IN_W(IN_W), .OUT_W(OUT_W), .DECIM(2), .DEPTH(DEPTH)) u_d2 (
        .clk(clk), .rst(rst), .in_data(in_data2), .in_valid(in_valid2),
        .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2),
        .level(level2), .overflow(overflow2)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int conv(input int x);
        int r;
        r = (x + (1 << (SHIFT - 1))) >> SHIFT;
        if (r > (1 << OUT_W) - 1) r = (1 << OUT_W) - 1;
        return r;
    endfunction

    function automatic void upd(inout int q[$], inout int ph, inout bit ov, input int decim,
                                input bit iv, input int din, input bit rdy);
        bit keep;
        keep = iv && (ph == 0);
        if (iv) ph = (ph + 1) % decim;
        if (rdy && q.size() > 0) void'(q.pop_front());
        if (keep) begin
            if (q.size() < DEPTH) q.push_back(conv(din));
            else ov = 1'b1;
        end
    endfunction

    task automatic model_reset();
        q1.delete(); q2.delete();
        ph1 = 0; ph2 = 0;
        ov1 = 1'b0; ov2 = 1'b0;
    endtask

    task automatic cmp_all();
        chk("d1_valid", out_valid1, q1.size() > 0);
        chk("d1_level", level1, q1.size());
        chk("d1_data",  out_data1, (q1.size() > 0) ? q1[0] : 0);
        chk("d1_ovf",   overflow1, ov1);
        chk("d2_valid", out_valid2, q2.size() > 0);
        chk("d2_level", level2, q2.size());
        chk("d2_data",  out_data2, (q2.size() > 0) ? q2[0] : 0);
        chk("d2_ovf",   overflow2, ov2);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            upd(q1, ph1, ov1, 1, in_valid1, int'(in_data1), out_ready1);
            upd(q2, ph2, ov2, 2, in_valid2, int'(in_data2), out_ready2);
        end
        #1;
        cmp_all();
    endtask

    // Assert reset between edges and look at outputs before any clock arrives.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_async_level1", level1, 0);
        chk("rst_async_valid1", out_valid1, 0);
        chk("rst_async_valid2", out_valid2, 0);
        cmp_all();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #2;
        model_reset();
        chk("rst_level", level1, 0);
        chk("rst_data",  out_data1, 0);
        chk("rst_ovf",   overflow2, 0);
        cmp_all();
        tick();
        rst = 1'b0;

        // Rounding and saturation, DECIM=1
        out_ready1 = 1'b1; in_valid1 = 1'b1;
        in_data1 = 19'd11;      tick(); chk("rnd_11",   out_data1, 1);
        in_data1 = 19'd12;      tick(); chk("rnd_12",   out_data1, 2);
        in_data1 = 19'h7FFFF;   tick(); chk("rnd_sat",  out_data1, 16'hFFFF);
        in_valid1 = 1'b0;       tick(); chk("rnd_empty", out_valid1, 0);

        // Decimation by two, continuous input
        out_ready2 = 1'b1; in_valid2 = 1'b1;
        in_data2 = 19'd8;  tick(); chk("dec_8",    out_data2, 1); chk("dec_8v", out_valid2, 1);
        in_data2 = 19'd16; tick(); chk("dec_16",   out_valid2, 0);
        in_data2 = 19'd24; tick(); chk("dec_24",   out_data2, 3); chk("dec_24v", out_valid2, 1);
        in_data2 = 19'd32; tick(); chk("dec_32",   out_valid2, 0);
        in_valid2 = 1'b0;  tick();

        // Gaps do not advance the phase
        out_ready2 = 1'b0;
        in_valid2 = 1'b1; in_data2 = 19'd8;  tick();
        in_valid2 = 1'b0;                    tick(); tick();
        in_valid2 = 1'b1; in_data2 = 19'd16; tick();
        in_valid2 = 1'b1; in_data2 = 19'd24; tick();
        in_valid2 = 1'b0;
        chk("gap_level", level2, 2); chk("gap_head1", out_data2, 1);
        out_ready2 = 1'b1; tick(); chk("gap_head2", out_data2, 3);
        tick(); chk("gap_empty", out_valid2, 0);

        // Overflow: nine writes into eight slots with no consumer
        out_ready1 = 1'b0; in_valid1 = 1'b1;
        for (int i = 1; i <= 9; i++) begin in_data1 = IN_W'(8 * i); tick(); end
        in_valid1 = 1'b0;
        chk("ovf_level", level1, 8); chk("ovf_flag", overflow1, 1);
        out_ready1 = 1'b1;
        for (int i = 1; i <= 8; i++) begin chk("ovf_drain", out_data1, i); tick(); end
        chk("ovf_gone", out_valid1, 0); chk("ovf_sticky", overflow1, 1);

        // Simultaneous push and pop while full
        do_reset();
        out_ready1 = 1'b0; in_valid1 = 1'b1;
        for (int i = 1; i <= 8; i++) begin in_data1 = IN_W'(8 * i); tick(); end
        in_data1 = 19'd80; out_ready1 = 1'b1; tick();
        in_valid1 = 1'b0;
        chk("full_pp_level", level1, 8); chk("full_pp_ovf", overflow1, 0);
        for (int i = 2; i <= 8; i++) begin chk("full_pp_order", out_data1, i); tick(); end
        chk("full_pp_last", out_data1, 10);
        tick(); chk("full_pp_empty", out_valid1, 0);

        // Reset with five samples buffered
        out_ready1 = 1'b0; in_valid1 = 1'b1;
        for (int i = 1; i <= 5; i++) begin in_data1 = IN_W'(8 * i); tick(); end
        in_valid1 = 1'b0;
        chk("mid_level5", level1, 5);
        do_reset();
        in_valid1 = 1'b1; in_data1 = 19'd16;
        in_valid2 = 1'b1; in_data2 = 19'd16; out_ready2 = 1'b0;
        tick();
        in_valid1 = 1'b0; in_valid2 = 1'b0;
        chk("mid_keep1", out_data1, 2); chk("mid_keep1v", out_valid1, 1);
        chk("mid_keep2", out_data2, 2);

        // Randomized traffic with varying consumer pressure
        for (int c = 0; c < 4000; c++) begin
            int pct1, pct2;
            pct1 = ((c / 200) % 3 == 0) ? 15 : (((c / 200) % 3 == 1) ? 55 : 90);
            pct2 = ((c / 300) % 3 == 0) ? 90 : (((c / 300) % 3 == 1) ? 10 : 50);
            in_valid1  = ($urandom_range(0, 99) < 70);
            in_valid2  = ($urandom_range(0, 99) < 70);
            out_ready1 = ($urandom_range(0, 99) < pct1);
            out_ready2 = ($urandom_range(0, 99) < pct2);
            in_data1 = ($urandom_range(0, 7) == 0) ? IN_W'(19'h7FFFF - $urandom_range(0, 15)) : IN_W'($urandom);
            in_data2 = ($urandom_range(0, 7) == 0) ? IN_W'(19'h7FFFF - $urandom_range(0, 15)) : IN_W'($urandom);
            if ($urandom_range(0, 999) == 0) do_reset();
            else tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
